mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback datapath of the 5-stage pipelined CPU.
- Captures the MEM-stage result and aligns/extends load data from the raw memory word.
- Selects the writeback value and drives the register file write port (RFWr, A3, WD).
- The same outputs feed the EX forwarding logic and the register file's WB-to-EX bypass.
- Also keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hold the WB register (downstream/structural stall).
- flush_i  in  1  load a bubble into the WB register.
- mem_valid_i  in  1  MEM stage holds a real instruction.
- mem_rd_i  in  5  destination register.
- mem_rf_wr_i  in  1  instruction writes rd.
- mem_wd_sel_i  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- mem_alu_i  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- mem_pc4_i  in  XLEN  PC+4 for JAL/JALR.
- mem_rdata_i  in  XLEN  raw aligned word from data memory.
- mem_ldtype_i  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW.
- rf_wr_o  out  1  to RF RFWr.
- rf_a3_o  out  5  to RF A3.
- rf_wd_o  out  XLEN  to RF WD.
- misalign_o  out  1  WB holds a misaligned load.
- wb_valid_o  out  1  WB register holds a real instruction.
- instret_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async): all WB fields = 0, so wb_valid_o=0, rf_wr_o=0, rf_a3_o=0, rf_wd_o=0, misalign_o=0, instret_o=0.
- Register update priority at posedge clk: flush_i > stall_i > load.
  - flush_i=1: bubble (valid=0, rf_wr=0); other fields don't-care but set to 0.
  - stall_i=1 and flush_i=0: all fields hold.
  - Otherwise: capture all mem_* inputs.
  - flush_i and stall_i together: bubble.
- Latency: one cycle from MEM to WB outputs. All outputs are combinational from registered fields only; no input-to-output combinational path. The RF commits on the following edge.
- Load extraction (only when wd_sel=01), using off = registered alu[1:0]:
  - LB/LBU: byte at bits [8*off+7 : 8*off], sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword at bits [16*off[1]+15 : 16*off[1]], sign- or zero-extended.
  - LW: whole word.
- Misalignment:
  - LH/LHU with off[0]=1, or LW (including reserved funct3) with off!=0 → misalign_o=1 while held, and rf_wr_o suppressed.
  - misalign_o is asserted only when valid && wd_sel=01.
- rf_wr_o = valid && rf_wr && (rd != 0) && !misalign_o.
- rf_a3_o = registered rd, always.
- rf_wd_o = selected value, always (even when rf_wr_o=0).
- While stalled, rf_wr_o stays asserted with identical A3/WD. The repeated write is idempotent and intended.
- instret_o:
  - Increments by 1 at a posedge where wb_valid && !stall_i, i.e. once per instruction leaving WB.
  - A misaligned load still counts.
  - A flush does not cancel the instruction currently in WB: it leaves that cycle and counts.
  - Wraps 2^CNT_W−1 → 0.
- Reset mid-operation: immediate clear, including the counter. The first capture occurs at the first posedge after rst deasserts.

Decomposition:
- Shared package cpu_pkg holds:
  - WD_SEL_ALU/MEM/PC4 constants.
  - LD_LB/LH/LW/LBU/LHU funct3 constants.
  - XLEN.
- One natural sub-module: load_align (purely combinational: rdata, off, ldtype → data, misalign). The EX-stage store path can reuse its constants.

Test Plan:
- Reset and ALU writeback: rst pulse, then MEM: valid, rd=5, rf_wr=1, sel=00, alu=0x1234_5678 → next cycle rf_wr_o=1, a3=5, wd=0x12345678; instret_o=1 after the following edge.
- Load sign/zero extension: rdata=0x80FF_7F01, alu=...02.
  - LB → wd=0xFFFFFFFF.
  - LBU → 0x000000FF.
  - With alu=...02: LH → 0xFFFF80FF, LHU → 0x000080FF.
  - With alu=...00: LW → 0x80FF7F01.
- Misaligned load: LW with alu=0x...01, rd=7 → misalign_o=1, rf_wr_o=0, instret_o still increments.
- x0 and JAL: rd=0, rf_wr=1 → rf_wr_o=0. Then sel=10, pc4=0x0000_0104, rd=1 → wd=0x104, rf_wr_o=1.
- Stall/flush priority:
  - Stall 3 cycles with a valid instruction in WB → outputs constant, instret_o unchanged until release, then +1 exactly once.
  - flush_i and stall_i together → bubble on the next edge (wb_valid_o=0).
- Counter wrap and async reset: force instret to 0xFFFF_FFFF, retire one → 0. Assert rst between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: writeback source selects, load funct3 codes and the
// WB-stage control record.
package cpu_pkg;
   localparam int XLEN = 32;

   localparam logic [1:0] WD_SEL_ALU = 2'b00;
   localparam logic [1:0] WD_SEL_MEM = 2'b01;
   localparam logic [1:0] WD_SEL_PC4 = 2'b10;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       rf_wr;
      logic [1:0] wd_sel;
      logic [2:0] ldtype;
   } wb_ctrl_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: MEM-stage result and control in, register-file write port out.
interface mem_wb_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             stall_i;
   logic             flush_i;
   logic             mem_valid_i;
   logic [4:0]       mem_rd_i;
   logic             mem_rf_wr_i;
   logic [1:0]       mem_wd_sel_i;
   logic [XLEN-1:0]  mem_alu_i;
   logic [XLEN-1:0]  mem_pc4_i;
   logic [XLEN-1:0]  mem_rdata_i;
   logic [2:0]       mem_ldtype_i;
   logic             rf_wr_o;
   logic [4:0]       rf_a3_o;
   logic [XLEN-1:0]  rf_wd_o;
   logic             misalign_o;
   logic             wb_valid_o;
   logic [CNT_W-1:0] instret_o;

   modport master (
      output stall_i, flush_i, mem_valid_i, mem_rd_i, mem_rf_wr_i, mem_wd_sel_i,
             mem_alu_i, mem_pc4_i, mem_rdata_i, mem_ldtype_i,
      input  rf_wr_o, rf_a3_o, rf_wd_o, misalign_o, wb_valid_o, instret_o
   );

   modport slave (
      input  stall_i, flush_i, mem_valid_i, mem_rd_i, mem_rf_wr_i, mem_wd_sel_i,
             mem_alu_i, mem_pc4_i, mem_rdata_i, mem_ldtype_i,
      output rf_wr_o, rf_a3_o, rf_wd_o, misalign_o, wb_valid_o, instret_o
   );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: picks the byte/halfword at the address offset out of the raw
// memory word, extends it, and flags offsets the load width cannot use.
module load_align #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      ldtype_i,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);
   import cpu_pkg::*;

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   always_comb begin
      byte_w     = rdata_i[{off_i, 3'b000} +: 8];
      half_w     = rdata_i[{off_i[1], 4'b0000} +: 16];
      data_o     = rdata_i;
      misalign_o = 1'b0;
      case (ldtype_i)
         LD_LB:  data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
         LD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_w};
         LD_LH: begin
            data_o     = {{(XLEN-16){half_w[15]}}, half_w};
            misalign_o = off_i[0];
         end
         LD_LHU: begin
            data_o     = {{(XLEN-16){1'b0}}, half_w};
            misalign_o = off_i[0];
         end
         // LW and the reserved funct3 codes all behave as a full-word load
         default: misalign_o = |off_i;
      endcase
   end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback mux driving the register-file write
// port, plus the retired-instruction counter.
module mem_wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_wb_stage_if.slave bus
);
   import cpu_pkg::*;

   wb_ctrl_t         ctrl_q, ctrl_d;
   logic [XLEN-1:0]  alu_q, alu_d;
   logic [XLEN-1:0]  pc4_q, pc4_d;
   logic [XLEN-1:0]  rdata_q, rdata_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic [XLEN-1:0]  ld_data;
   logic             ld_misalign;
   logic             misalign;

   always_comb begin
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      pc4_d   = pc4_q;
      rdata_d = rdata_q;
      if (bus.flush_i) begin
         ctrl_d  = '0;
         alu_d   = '0;
         pc4_d   = '0;
         rdata_d = '0;
      end else if (!bus.stall_i) begin
         ctrl_d.valid  = bus.mem_valid_i;
         ctrl_d.rd     = bus.mem_rd_i;
         ctrl_d.rf_wr  = bus.mem_rf_wr_i;
         ctrl_d.wd_sel = bus.mem_wd_sel_i;
         ctrl_d.ldtype = bus.mem_ldtype_i;
         alu_d         = bus.mem_alu_i;
         pc4_d         = bus.mem_pc4_i;
         rdata_d       = bus.mem_rdata_i;
      end
   end

   // An instruction retires when it leaves WB; a flush still lets it leave.
   always_comb begin
      instret_d = instret_q;
      if (ctrl_q.valid && !bus.stall_i)
         instret_d = instret_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= '0;
         alu_q     <= '0;
         pc4_q     <= '0;
         rdata_q   <= '0;
         instret_q <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         alu_q     <= alu_d;
         pc4_q     <= pc4_d;
         rdata_q   <= rdata_d;
         instret_q <= instret_d;
      end
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata_i    (rdata_q),
      .off_i      (alu_q[1:0]),
      .ldtype_i   (ctrl_q.ldtype),
      .data_o     (ld_data),
      .misalign_o (ld_misalign)
   );

   assign misalign = ctrl_q.valid && (ctrl_q.wd_sel == WD_SEL_MEM) && ld_misalign;

   always_comb begin
      case (ctrl_q.wd_sel)
         WD_SEL_MEM: bus.rf_wd_o = ld_data;
         WD_SEL_PC4: bus.rf_wd_o = pc4_q;
         default:    bus.rf_wd_o = alu_q;
      endcase
   end

   assign bus.rf_wr_o    = ctrl_q.valid && ctrl_q.rf_wr && (ctrl_q.rd != 5'd0) && !misalign;
   assign bus.rf_a3_o    = ctrl_q.rd;
   assign bus.misalign_o = misalign;
   assign bus.wb_valid_o = ctrl_q.valid;
   assign bus.instret_o  = instret_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage; a second narrow-counter instance
// exercises counter wrap.
module tb_mem_wb_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   mem_wb_stage_if #(.XLEN(32), .CNT_W(32)) bus ();
   mem_wb_stage_if #(.XLEN(32), .CNT_W(3))  sbus ();

   mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   mem_wb_stage #(.XLEN(32), .CNT_W(3))  dut_w (.clk(clk), .rst(rst), .bus(sbus));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic wr,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [31:0] rdata,
                        input logic [2:0] lt);
      bus.mem_valid_i  = v;
      bus.mem_rd_i     = rd;
      bus.mem_rf_wr_i  = wr;
      bus.mem_wd_sel_i = sel;
      bus.mem_alu_i    = alu;
      bus.mem_pc4_i    = pc4;
      bus.mem_rdata_i  = rdata;
      bus.mem_ldtype_i = lt;
   endtask

   task automatic chk_wb(input string tag, input logic wr, input logic [4:0] a3,
                         input logic [31:0] wd, input logic mis, input logic [31:0] cnt);
      chk({tag, ".wr"}, bus.rf_wr_o, wr);
      chk({tag, ".a3"}, bus.rf_a3_o, a3);
      chk({tag, ".wd"}, bus.rf_wd_o, wd);
      chk({tag, ".mis"}, bus.misalign_o, mis);
      chk({tag, ".cnt"}, bus.instret_o, cnt);
   endtask

   initial begin
      bus.stall_i = 0;
      bus.flush_i = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sbus.stall_i = 0; sbus.flush_i = 0; sbus.mem_valid_i = 0; sbus.mem_rd_i = 0;
      sbus.mem_rf_wr_i = 0; sbus.mem_wd_sel_i = 0; sbus.mem_alu_i = 0;
      sbus.mem_pc4_i = 0; sbus.mem_rdata_i = 0; sbus.mem_ldtype_i = 0;

      #2 rst = 1;
      #2;
      chk("rst.valid", bus.wb_valid_o, 0);
      chk_wb("rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 0;

      // ALU writeback
      drive(1, 5, 1, 2'b00, 32'h1234_5678, 0, 0, 3'b010);
      tick();
      chk("alu.valid", bus.wb_valid_o, 1);
      chk_wb("alu", 1, 5, 32'h1234_5678, 0, 0);

      // Loads from 0x80FF7F01
      drive(1, 6, 1, 2'b01, 32'h0000_1002, 0, 32'h80FF_7F01, 3'b000);
      tick();
      chk_wb("lb", 1, 6, 32'hFFFF_FFFF, 0, 1);
      drive(1, 6, 1, 2'b01, 32'h0000_1002, 0, 32'h80FF_7F01, 3'b100);
      tick();
      chk_wb("lbu", 1, 6, 32'h0000_00FF, 0, 2);
      drive(1, 6, 1, 2'b01, 32'h0000_1002, 0, 32'h80FF_7F01, 3'b001);
      tick();
      chk_wb("lh", 1, 6, 32'hFFFF_80FF, 0, 3);
      drive(1, 6, 1, 2'b01, 32'h0000_1002, 0, 32'h80FF_7F01, 3'b101);
      tick();
      chk_wb("lhu", 1, 6, 32'h0000_80FF, 0, 4);
      drive(1, 6, 1, 2'b01, 32'h0000_1000, 0, 32'h80FF_7F01, 3'b010);
      tick();
      chk_wb("lw", 1, 6, 32'h80FF_7F01, 0, 5);
      drive(1, 6, 1, 2'b01, 32'h0000_1001, 0, 32'h80FF_7F01, 3'b000);
      tick();
      chk_wb("lb.off1", 1, 6, 32'h0000_007F, 0, 6);

      // Misaligned LW and LH
      drive(1, 7, 1, 2'b01, 32'h0000_1001, 0, 32'h80FF_7F01, 3'b010);
      tick();
      chk("mislw.mis", bus.misalign_o, 1);
      chk("mislw.wr", bus.rf_wr_o, 0);
      chk("mislw.cnt", bus.instret_o, 7);
      drive(1, 7, 1, 2'b01, 32'h0000_1003, 0, 32'h80FF_7F01, 3'b101);
      tick();
      chk("mislhu.mis", bus.misalign_o, 1);
      chk("mislhu.wr", bus.rf_wr_o, 0);
      chk("mislhu.cnt", bus.instret_o, 8);

      // Misaligned offset on an ALU op is not a misalign; x0 write suppressed
      drive(1, 0, 1, 2'b00, 32'h0000_0003, 0, 0, 3'b010);
      tick();
      chk_wb("x0", 0, 0, 32'h0000_0003, 0, 9);

      // JAL: PC+4 writeback
      drive(1, 1, 1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0104, 0, 3'b010);
      tick();
      chk_wb("jal", 1, 1, 32'h0000_0104, 0, 10);

      // Stall 3 cycles with JAL held
      bus.stall_i = 1;
      drive(1, 9, 1, 2'b00, 32'h0000_0AAA, 0, 0, 3'b010);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_wb("stall", 1, 1, 32'h0000_0104, 0, 10);
      end
      bus.stall_i = 0;
      tick();
      chk_wb("unstall", 1, 9, 32'h0000_0AAA, 0, 11);

      // Flush + stall: bubble, held instruction does not count
      bus.flush_i = 1;
      bus.stall_i = 1;
      tick();
      chk("fs.valid", bus.wb_valid_o, 0);
      chk_wb("fs", 0, 0, 0, 0, 11);

      // Flush alone: WB instruction still retires
      bus.flush_i = 0;
      bus.stall_i = 0;
      drive(1, 3, 1, 2'b00, 32'h0000_0033, 0, 0, 3'b010);
      tick();
      chk_wb("pre.flush", 1, 3, 32'h0000_0033, 0, 11);
      bus.flush_i = 1;
      tick();
      chk("flush.valid", bus.wb_valid_o, 0);
      chk("flush.cnt", bus.instret_o, 12);
      bus.flush_i = 0;
      drive(0, 4, 1, 2'b00, 32'h0000_0044, 0, 0, 3'b010);
      tick();
      chk("bubble.wr", bus.rf_wr_o, 0);
      chk("bubble.cnt", bus.instret_o, 12);

      // Async reset mid-operation
      drive(1, 8, 1, 2'b00, 32'h0000_0088, 0, 0, 3'b010);
      tick();
      chk("prerst.wr", bus.rf_wr_o, 1);
      #2 rst = 1;
      #1;
      chk("arst.valid", bus.wb_valid_o, 0);
      chk_wb("arst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 0;
      tick();
      chk_wb("post.rst", 1, 8, 32'h0000_0088, 0, 0);

      // Counter wrap on the 3-bit instance: 8 retirements bring it back to 0
      sbus.mem_valid_i = 1;
      tick();
      for (int i = 1; i < 8; i++) tick();
      chk("wrap.7", sbus.instret_o, 3'd7);
      tick();
      chk("wrap.0", sbus.instret_o, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
